// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data RAM (combinational read, write on
// the clock edge) between the multicycle CPU and a host/loader burst port.
//
// Ports
//   CLOCK_50, rst_n      : clock, synchronous active-low reset
//   cpu_*                : CPU single-word lw/sw (byte address), level request,
//                          one-cycle cpu_ack with cpu_rdata
//   host_*               : host burst port (word address, beat count),
//                          host_wready / host_rvalid per beat, host_done pulse
//   mem_wr_en/index/entry: RAM control pins; mem_rdata is the RAM read data
//
// Build option
//   DMEM_ARB_HOST_PRIO_EN : when defined, a CPU/host tie in IDLE always goes to
//                           the host (program-load phases); otherwise the tie
//                           is resolved round-robin on last_grant.
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LEN_W  = 5
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [LEN_W-1:0]  host_len,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_wready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_busy,
  output logic              host_done,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_index,
  output logic [DATA_W-1:0] mem_entry,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CPU_ACC  = 2'd1;
  localparam logic [1:0] HOST_ACC = 2'd2;

  localparam logic GRANT_CPU  = 1'b0;
  localparam logic GRANT_HOST = 1'b1;

  logic [1:0]        state;
  logic              last_grant;

  logic              cpu_we_p0;
  logic [ADDR_W-1:0] cpu_idx_p0;
  logic [DATA_W-1:0] cpu_wdata_p0;

  logic              host_we_p0;
  logic [ADDR_W-1:0] host_base_p0;
  logic [LEN_W-1:0]  host_last_p0;
  logic [LEN_W-1:0]  host_cnt_p0;

  logic [ADDR_W-1:0] idx_hold;
  logic [DATA_W-1:0] entry_hold;

  logic              cpu_elig;
  logic              host_elig;
  logic              grant_cpu;
  logic              grant_host;
  logic [ADDR_W-1:0] host_idx;

  // Only the word-index bits of the CPU byte address select a RAM entry.
  logic unused_cpu_addr;
  assign unused_cpu_addr = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

`ifdef DMEM_ARB_HOST_PRIO_EN
  // last_grant is still tracked but does not steer ties in this build.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // A requester is not eligible in the cycle its completion pulse is high,
  // since it has not yet had a chance to drop its level request.
  assign cpu_elig  = cpu_req  & ~cpu_ack;
  assign host_elig = host_req & ~host_done;

  always_comb begin
    grant_cpu  = 1'b0;
    grant_host = 1'b0;
    if (state == IDLE) begin
      if (cpu_elig && host_elig) begin
`ifdef DMEM_ARB_HOST_PRIO_EN
        grant_host = 1'b1;
`else
        grant_cpu  = (last_grant == GRANT_HOST);
        grant_host = (last_grant == GRANT_CPU);
`endif
      end else begin
        grant_cpu  = cpu_elig;
        grant_host = host_elig;
      end
    end
  end

  // Burst address wraps modulo the RAM index space.
  assign host_idx  = host_base_p0 + ADDR_W'(host_cnt_p0);
  assign host_busy = (state == HOST_ACC);

  // RAM pins. Writes are gated by rst_n so a reset asserted mid-burst stops
  // RAM updates in that very cycle; outside an access the index/entry hold.
  always_comb begin
    mem_wr_en   = 1'b0;
    host_wready = 1'b0;
    mem_index   = idx_hold;
    mem_entry   = entry_hold;
    case (state)
      CPU_ACC: begin
        mem_index = cpu_idx_p0;
        mem_entry = cpu_wdata_p0;
        mem_wr_en = cpu_we_p0 & rst_n;
      end
      HOST_ACC: begin
        mem_index = host_idx;
        if (host_we_p0) begin
          mem_entry   = host_wdata;
          mem_wr_en   = rst_n;
          host_wready = rst_n;
        end
      end
      default: ;
    endcase
  end

  // ---- stage p0: arbitration / sequencing control ----
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= GRANT_HOST;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      host_done   <= 1'b0;
      idx_hold    <= '0;
      entry_hold  <= '0;
    end else begin
      cpu_ack     <= 1'b0;
      host_rvalid <= 1'b0;
      host_done   <= 1'b0;
      idx_hold    <= mem_index;
      entry_hold  <= mem_entry;
      case (state)
        IDLE: begin
          if (grant_cpu) begin
            state      <= CPU_ACC;
            last_grant <= GRANT_CPU;
          end else if (grant_host) begin
            state      <= HOST_ACC;
            last_grant <= GRANT_HOST;
          end
        end
        CPU_ACC: begin
          // mem_rdata is the pre-write content of the index this cycle.
          cpu_rdata <= mem_rdata;
          cpu_ack   <= 1'b1;
          state     <= IDLE;
        end
        HOST_ACC: begin
          if (!host_we_p0) begin
            host_rdata  <= mem_rdata;
            host_rvalid <= 1'b1;
          end
          if (host_cnt_p0 == host_last_p0) begin
            state     <= IDLE;
            host_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p0: access descriptors latched at grant ----
  always_ff @(posedge CLOCK_50) begin
    if (grant_cpu) begin
      cpu_we_p0    <= cpu_we;
      cpu_idx_p0   <= cpu_addr[ADDR_W+1:2];
      cpu_wdata_p0 <= cpu_wdata;
    end
    if (grant_host) begin
      host_we_p0   <= host_we;
      host_base_p0 <= host_addr;
      // A zero-length burst runs one beat, same as length 1.
      host_last_p0 <= (host_len == '0) ? '0 : host_len - LEN_W'(1);
      host_cnt_p0  <= '0;
    end else if (state == HOST_ACC) begin
      host_cnt_p0  <= host_cnt_p0 + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural RAM is attached to the
// mem_* pins, and a separate array model_ram holds the content the RAM should
// have according to the completed CPU / host transactions.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        host_req, host_we;
  logic [4:0]  host_addr, host_len;
  logic [31:0] host_wdata;
  logic        host_wready, host_rvalid, host_busy, host_done;
  logic [31:0] host_rdata;
  logic        mem_wr_en;
  logic [4:0]  mem_index;
  logic [31:0] mem_entry, mem_rdata;

  logic [31:0] ram       [0:31];
  logic [31:0] model_ram [0:31];
  logic [31:0] hw_data   [0:31];
  logic [31:0] rq [$];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(5), .LEN_W(5)) dut (
    .CLOCK_50(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_len(host_len),
    .host_wdata(host_wdata), .host_wready(host_wready), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .host_busy(host_busy), .host_done(host_done),
    .mem_wr_en(mem_wr_en), .mem_index(mem_index), .mem_entry(mem_entry),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = ram[mem_index];
  always @(posedge clk) if (mem_wr_en) ram[mem_index] <= mem_entry;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One CPU access; returns load data, ack latency (cycles after request),
  // number of write-enable cycles and the RAM index seen one cycle in.
  task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output int wrc,
                        output logic [4:0] idx);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    rd = '0; lat = -1; wrc = 0; idx = '0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (c == 1) idx = mem_index;
      if (mem_wr_en) wrc++;
      if (cpu_ack) begin
        lat = c;
        rd  = cpu_rdata;
        break;
      end
      next_cycle();
    end
    next_cycle();
    cpu_req = 1'b0;
  endtask

  // One host burst using hw_data as write beats; read beats land in rq.
  task automatic host_burst(input logic we, input logic [4:0] base, input logic [4:0] len,
                            output int beats, output int busy, output int dones,
                            output int errs, output int runs);
    int ib;
    int done_c;
    logic prev_rv;
    logic [4:0] exp_idx;
    beats = 0; busy = 0; dones = 0; errs = 0; runs = 0; ib = 0; done_c = -1;
    prev_rv = 1'b0;
    rq.delete();
    host_we = we; host_addr = base; host_len = len; host_req = 1'b1;
    for (int c = 0; c < 80; c++) begin
      host_wdata = hw_data[beats % 32];
      @(negedge clk);
      if (host_busy) begin
        exp_idx = base + 5'(ib);
        if (mem_index !== exp_idx) errs++;
        if (mem_wr_en !== we) errs++;
        if (host_wready !== we) errs++;
        if (we && (mem_entry !== host_wdata)) errs++;
        ib++;
        busy++;
      end
      if (host_wready) beats++;
      if (host_rvalid) begin
        rq.push_back(host_rdata);
        if (!prev_rv) runs++;
      end
      prev_rv = host_rvalid;
      if (host_done) begin
        dones++;
        if (done_c < 0) done_c = c;
      end
      next_cycle();
      if (done_c >= 0) host_req = 1'b0;
      if (done_c >= 0 && c >= done_c + 2) break;
    end
    host_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({cpu_ack, host_rvalid, host_done, host_busy, host_wready, mem_wr_en} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {cpu_ack, host_rvalid, host_done, host_busy, host_wready, mem_wr_en});
    end
    n_cmp++;
    if (cpu_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_cpu_rdata: got %h required 0", cpu_rdata);
    end
    n_cmp++;
    if (host_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_host_rdata: got %h required 0", host_rdata);
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_cpu_sw_lw();
    logic [31:0] rd;
    int lat, wrc;
    logic [4:0] idx;
    cpu_op(1'b1, 32'h0000_000C, 32'hDEAD_BEEF, rd, lat, wrc, idx);
    model_ram[3] = 32'hDEAD_BEEF;
    n_cmp++;
    if (idx !== 5'd3) begin n_fail++; $display("FAIL sw_index: got %0d required 3", idx); end
    n_cmp++;
    if (wrc !== 1) begin n_fail++; $display("FAIL sw_wr_cycles: got %0d required 1", wrc); end
    n_cmp++;
    if (lat !== 2) begin n_fail++; $display("FAIL sw_ack_latency: got %0d required 2", lat); end
    cpu_op(1'b0, 32'h0000_000C, 32'h0, rd, lat, wrc, idx);
    n_cmp++;
    if (rd !== model_ram[3]) begin
      n_fail++; $display("FAIL lw_rdata: got %h required %h", rd, model_ram[3]);
    end
    n_cmp++;
    if (lat !== 2) begin n_fail++; $display("FAIL lw_ack_latency: got %0d required 2", lat); end
    n_cmp++;
    if (wrc !== 0) begin n_fail++; $display("FAIL lw_wr_cycles: got %0d required 0", wrc); end
  endtask

  task automatic test_host_write_wrap();
    int beats, busy, dones, errs, runs;
    logic [4:0] a;
    for (int i = 0; i < 4; i++) hw_data[i] = 32'(i + 1);
    host_burst(1'b1, 5'd30, 5'd4, beats, busy, dones, errs, runs);
    for (int i = 0; i < 4; i++) begin
      a = 5'd30 + 5'(i);
      model_ram[a] = hw_data[i];
    end
    n_cmp++;
    if (beats !== 4) begin n_fail++; $display("FAIL hw_wready_cycles: got %0d required 4", beats); end
    n_cmp++;
    if (dones !== 1) begin n_fail++; $display("FAIL hw_done_pulses: got %0d required 1", dones); end
    n_cmp++;
    if (errs !== 0) begin n_fail++; $display("FAIL hw_beat_pins: got %0d errors required 0", errs); end
    for (int i = 0; i < 4; i++) begin
      a = 5'd30 + 5'(i);
      n_cmp++;
      if (ram[a] !== 32'(i + 1)) begin
        n_fail++; $display("FAIL hw_ram[%0d]: got %h required %h", a, ram[a], i + 1);
      end
    end
  endtask

  task automatic test_host_read();
    int beats, busy, dones, errs, runs;
    logic [4:0] a;
    host_burst(1'b0, 5'd30, 5'd4, beats, busy, dones, errs, runs);
    n_cmp++;
    if (rq.size() !== 4) begin n_fail++; $display("FAIL hr_rvalid_beats: got %0d required 4", rq.size()); end
    n_cmp++;
    if (runs !== 1) begin n_fail++; $display("FAIL hr_rvalid_contiguous: got %0d runs required 1", runs); end
    n_cmp++;
    if (busy !== 4) begin n_fail++; $display("FAIL hr_busy_cycles: got %0d required 4", busy); end
    n_cmp++;
    if (dones !== 1) begin n_fail++; $display("FAIL hr_done_pulses: got %0d required 1", dones); end
    n_cmp++;
    if (errs !== 0) begin n_fail++; $display("FAIL hr_beat_pins: got %0d errors required 0", errs); end
    for (int i = 0; i < rq.size(); i++) begin
      a = 5'd30 + 5'(i);
      n_cmp++;
      if (rq[i] !== model_ram[a]) begin
        n_fail++; $display("FAIL hr_rdata[%0d]: got %h required %h", i, rq[i], model_ram[a]);
      end
    end
  endtask

  task automatic test_len_zero();
    int beats, busy, dones, errs, runs;
    hw_data[0] = 32'hA5A5_0001;
    hw_data[1] = 32'hA5A5_0002;
    host_burst(1'b1, 5'd17, 5'd0, beats, busy, dones, errs, runs);
    model_ram[17] = hw_data[0];
    n_cmp++;
    if (beats !== 1) begin n_fail++; $display("FAIL len0_beats: got %0d required 1", beats); end
    n_cmp++;
    if (busy !== 1) begin n_fail++; $display("FAIL len0_busy: got %0d required 1", busy); end
    n_cmp++;
    if (dones !== 1) begin n_fail++; $display("FAIL len0_done: got %0d required 1", dones); end
    n_cmp++;
    if (ram[17] !== model_ram[17]) begin
      n_fail++; $display("FAIL len0_ram17: got %h required %h", ram[17], model_ram[17]);
    end
    n_cmp++;
    if (ram[18] !== model_ram[18]) begin
      n_fail++; $display("FAIL len0_ram18: got %h required %h", ram[18], model_ram[18]);
    end
  endtask

  task automatic test_tie();
    int first_host, cpu_lat, exp_first, exp_lat;
    logic hdone;
    logic [31:0] rd;
`ifdef DMEM_ARB_HOST_PRIO_EN
    exp_first = 1;
`else
    exp_first = 0;
`endif
    // host read of 2 beats: a host-first tie delays the CPU by 2 beats + done cycle
    exp_lat = exp_first ? (2 + 2 + 1) : 2;
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    for (int t = 0; t < 2; t++) begin
      cpu_we = 1'b0; cpu_addr = 32'h0000_0014; host_we = 1'b0; host_addr = 5'd20; host_len = 5'd2;
      cpu_req = 1'b1; host_req = 1'b1;
      first_host = -1; cpu_lat = -1; hdone = 1'b0; rd = '0;
      for (int c = 0; c < 80; c++) begin
        @(negedge clk);
        if (first_host < 0) begin
          if (host_busy) first_host = 1;
          else if (cpu_ack) first_host = 0;
        end
        if (cpu_ack && cpu_lat < 0) begin cpu_lat = c; rd = cpu_rdata; end
        if (host_done) hdone = 1'b1;
        next_cycle();
        if (cpu_lat >= 0) cpu_req = 1'b0;
        if (hdone) host_req = 1'b0;
        if (cpu_lat >= 0 && hdone) break;
      end
      cpu_req = 1'b0; host_req = 1'b0;
      n_cmp++;
      if (first_host !== exp_first) begin
        n_fail++; $display("FAIL tie%0d_winner_host: got %0d required %0d", t, first_host, exp_first);
      end
      n_cmp++;
      if (cpu_lat !== exp_lat) begin
        n_fail++; $display("FAIL tie%0d_cpu_latency: got %0d required %0d", t, cpu_lat, exp_lat);
      end
      n_cmp++;
      if (rd !== model_ram[5]) begin
        n_fail++; $display("FAIL tie%0d_cpu_rdata: got %h required %h", t, rd, model_ram[5]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int extra_done, extra_wr;
    for (int i = 0; i < 8; i++) hw_data[i] = 32'hC0DE_0000 + 32'(i);
    host_we = 1'b1; host_addr = 5'd8; host_len = 5'd8; host_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      host_wdata = hw_data[(c == 0) ? 0 : c - 1];
      next_cycle();
    end
    // third burst cycle = beat 2
    host_wdata = hw_data[2];
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({host_busy, mem_wr_en, host_wready} !== 3'b100) begin
      n_fail++; $display("FAIL rstmid_beat2_pins: got busy/wr/wready %b required 100",
                         {host_busy, mem_wr_en, host_wready});
    end
    next_cycle();
    rst_n = 1'b1;
    host_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cpu_ack, host_rvalid, host_done, host_busy, host_wready, mem_wr_en} !== 6'b0 ||
        cpu_rdata !== 32'h0 || host_rdata !== 32'h0 || mem_index !== 5'd0 || mem_entry !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: got ctrl %b idx %0d entry %h required all zero",
                         {cpu_ack, host_rvalid, host_done, host_busy, host_wready, mem_wr_en},
                         mem_index, mem_entry);
    end
    extra_done = 0; extra_wr = 0;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      @(negedge clk);
      if (host_done) extra_done++;
      if (mem_wr_en) extra_wr++;
    end
    next_cycle();
    n_cmp++;
    if (extra_done !== 0 || extra_wr !== 0) begin
      n_fail++; $display("FAIL rstmid_after: got done %0d wr %0d required 0 0", extra_done, extra_wr);
    end
    model_ram[8] = hw_data[0];
    model_ram[9] = hw_data[1];
    for (int i = 8; i < 16; i++) begin
      n_cmp++;
      if (ram[i] !== model_ram[i]) begin
        n_fail++; $display("FAIL rstmid_ram[%0d]: got %h required %h", i, ram[i], model_ram[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] addr, wd, rd;
    logic [4:0] idx, base, len, a;
    int lat, wrc, n, beats, busy, dones, errs, runs;
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          addr = $urandom; wd = $urandom;
          if ($urandom_range(0, 1) == 1) begin
            cpu_op(1'b1, addr, wd, rd, lat, wrc, idx);
            model_ram[addr[6:2]] = wd;
            n_cmp++;
            if (wrc !== 1 || lat !== 2 || idx !== addr[6:2]) begin
              n_fail++; $display("FAIL rnd_sw: got wr %0d lat %0d idx %0d required 1 2 %0d",
                                 wrc, lat, idx, addr[6:2]);
            end
          end else begin
            cpu_op(1'b0, addr, wd, rd, lat, wrc, idx);
            n_cmp++;
            if (rd !== model_ram[addr[6:2]] || lat !== 2 || wrc !== 0) begin
              n_fail++; $display("FAIL rnd_lw: got %h lat %0d wr %0d required %h 2 0",
                                 rd, lat, wrc, model_ram[addr[6:2]]);
            end
          end
        end
        2: begin
          base = 5'($urandom); len = 5'($urandom);
          n = (len == 0) ? 1 : int'(len);
          for (int i = 0; i < 32; i++) hw_data[i] = $urandom;
          host_burst(1'b1, base, len, beats, busy, dones, errs, runs);
          for (int i = 0; i < n; i++) begin
            a = base + 5'(i);
            model_ram[a] = hw_data[i];
          end
          n_cmp++;
          if (beats !== n || dones !== 1 || errs !== 0) begin
            n_fail++; $display("FAIL rnd_hwrite: got beats %0d done %0d err %0d required %0d 1 0",
                               beats, dones, errs, n);
          end
        end
        default: begin
          base = 5'($urandom); len = 5'($urandom);
          n = (len == 0) ? 1 : int'(len);
          host_burst(1'b0, base, len, beats, busy, dones, errs, runs);
          n_cmp++;
          if (rq.size() !== n || dones !== 1 || errs !== 0 || runs !== 1) begin
            n_fail++; $display("FAIL rnd_hread: got beats %0d done %0d err %0d runs %0d required %0d 1 0 1",
                               rq.size(), dones, errs, runs, n);
          end
          for (int i = 0; i < rq.size(); i++) begin
            a = base + 5'(i);
            n_cmp++;
            if (rq[i] !== model_ram[a]) begin
              n_fail++; $display("FAIL rnd_hread_data[%0d]: got %h required %h", i, rq[i], model_ram[a]);
            end
          end
        end
      endcase
    end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (ram[i] !== model_ram[i]) begin
        n_fail++; $display("FAIL final_ram[%0d]: got %h required %h", i, ram[i], model_ram[i]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_len = '0; host_wdata = '0;
    for (int i = 0; i < 32; i++) begin
      ram[i]       = $urandom;
      model_ram[i] = ram[i];
      hw_data[i]   = '0;
    end
    test_reset();
    test_cpu_sw_lw();
    test_host_write_wrap();
    test_host_read();
    test_len_zero();
    test_tie();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
